// File: rtl/pause_fade_ctrl_if.sv
// Pause/dim controller bus: core-side controls and pixel in, registered pixel and status out.
// Latency: none (wiring only).
// Backpressure: none; every signal is a per-cycle level.
interface pause_fade_ctrl_if #(
    parameter int CW        = 4,
    parameter int NCH       = 3,
    parameter int DIM_SHIFT = 1
);
    localparam int DLW = $clog2(DIM_SHIFT + 1);

    logic                  pause_btn;
    logic                  pause_req;
    logic                  wake;
    logic [NCH*CW-1:0]     rgb_in;
    logic [NCH*CW-1:0]     rgb_out;
    logic                  pause;
    logic                  dimmed;
    logic [DLW-1:0]        dim_level;

    modport master (
        output pause_btn, pause_req, wake, rgb_in,
        input  rgb_out, pause, dimmed, dim_level
    );

    modport slave (
        input  pause_btn, pause_req, wake, rgb_in,
        output rgb_out, pause, dimmed, dim_level
    );
endinterface

// File: rtl/pause_fade_ctrl.sv
// Merges user/external pause into a registered pause and fades the picture after an idle timeout.
// Latency: pause/dimmed/dim_level one edge after the request; rgb_out one cycle behind rgb_in.
// Backpressure: none; the pixel path runs every cycle and wake overrides any fade in progress.
module pause_fade_ctrl #(
    parameter int CW          = 4,
    parameter int NCH         = 3,
    parameter int DIM_TIMEOUT = 32'h7270E00,
    parameter int STEP_CYCLES = 1048576,
    parameter int DIM_SHIFT   = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    pause_fade_ctrl_if.slave bus
);
    localparam int TW  = (DIM_TIMEOUT > 0) ? $clog2(DIM_TIMEOUT + 1) : 1;
    localparam int SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int DLW = $clog2(DIM_SHIFT + 1);

    localparam logic [TW-1:0]  TIMEOUT_V = TW'(DIM_TIMEOUT);
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [DLW-1:0] SHIFT_MAX = DLW'(DIM_SHIFT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_FADING,
        ST_DIMMED
    } state_t;

    state_t            state_q, state_d;
    logic              toggle_q, toggle_d;
    logic              btn_old_q, btn_old_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     step_cnt_q, step_cnt_d;
    logic [DLW-1:0]    dim_level_q, dim_level_d;
    logic              pause_q, pause_d;
    logic              dimmed_q, dimmed_d;
    logic [NCH*CW-1:0] rgb_q, rgb_d;

    logic              btn_rise;
    logic              want;
    logic [DLW-1:0]    dim_inc;

    // Pause request path and fade state machine
    always_comb begin
        btn_rise    = bus.pause_btn & ~btn_old_q;
        btn_old_d   = bus.pause_btn;
        toggle_d    = toggle_q ^ btn_rise;
        want        = toggle_d | bus.pause_req;
        dim_inc     = dim_level_q + 1'b1;

        state_d     = state_q;
        timer_d     = timer_q;
        step_cnt_d  = step_cnt_q;
        dim_level_d = dim_level_q;

        case (state_q)
            ST_RUN: begin
                if (want) begin
                    state_d     = ST_PAUSED;
                    timer_d     = '0;
                    dim_level_d = '0;
                end
            end
            ST_PAUSED: begin
                if (!want) begin
                    state_d = ST_RUN;
                end else if (bus.wake) begin
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_V) begin
                    state_d    = ST_FADING;
                    step_cnt_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_FADING: begin
                if (!want) begin
                    state_d     = ST_RUN;
                    dim_level_d = '0;
                end else if (bus.wake) begin
                    state_d     = ST_PAUSED;
                    timer_d     = '0;
                    dim_level_d = '0;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d  = '0;
                    dim_level_d = dim_inc;
                    if (dim_inc == SHIFT_MAX) begin
                        state_d = ST_DIMMED;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            ST_DIMMED: begin
                if (!want) begin
                    state_d     = ST_RUN;
                    dim_level_d = '0;
                end else if (bus.wake) begin
                    state_d     = ST_PAUSED;
                    timer_d     = '0;
                    dim_level_d = '0;
                end
            end
            default: begin
                state_d     = ST_RUN;
                dim_level_d = '0;
            end
        endcase

        pause_d  = (state_d != ST_RUN);
        dimmed_d = (state_d == ST_DIMMED);
    end

    // Per-channel logical shift; a shift of CW naturally yields zero
    always_comb begin
        rgb_d = '0;
        for (int i = 0; i < NCH; i++) begin
            rgb_d[i*CW +: CW] = bus.rgb_in[i*CW +: CW] >> dim_level_q;
        end
    end

    // btn_old resets high so a button held through reset release is not seen as a press
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            toggle_q    <= 1'b0;
            btn_old_q   <= 1'b1;
            timer_q     <= '0;
            step_cnt_q  <= '0;
            dim_level_q <= '0;
            pause_q     <= 1'b0;
            dimmed_q    <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            toggle_q    <= toggle_d;
            btn_old_q   <= btn_old_d;
            timer_q     <= timer_d;
            step_cnt_q  <= step_cnt_d;
            dim_level_q <= dim_level_d;
            pause_q     <= pause_d;
            dimmed_q    <= dimmed_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.rgb_out   = rgb_q;
    assign bus.pause     = pause_q;
    assign bus.dimmed    = dimmed_q;
    assign bus.dim_level = dim_level_q;

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs tagged with the clock edge they apply after.
// Two instances: A (timeout 10, step 4, shift 2) and B (timeout 2, step 2, full shift 4).
module tb_pause_fade_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   edge_cnt = 0;
    int   base;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    pause_fade_ctrl_if #(.CW(4), .NCH(3), .DIM_SHIFT(2)) a_if ();
    pause_fade_ctrl_if #(.CW(4), .NCH(3), .DIM_SHIFT(4)) b_if ();

    pause_fade_ctrl #(.CW(4), .NCH(3), .DIM_TIMEOUT(10), .STEP_CYCLES(4), .DIM_SHIFT(2)) u_dut_a (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (a_if.slave)
    );

    pause_fade_ctrl #(.CW(4), .NCH(3), .DIM_TIMEOUT(2), .STEP_CYCLES(2), .DIM_SHIFT(4)) u_dut_b (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (b_if.slave)
    );

    typedef struct {
        int          edge_no;
        int          dut;
        bit          p;
        bit          d;
        int          lvl;
        logic [11:0] rgb;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Monitor: compare every expectation whose edge has been reached
    always @(negedge clk) begin
        bit          ap;
        bit          ad;
        int          al;
        logic [11:0] ar;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                ap = a_if.pause; ad = a_if.dimmed; al = int'(a_if.dim_level); ar = a_if.rgb_out;
            end else begin
                ap = b_if.pause; ad = b_if.dimmed; al = int'(b_if.dim_level); ar = b_if.rgb_out;
            end
            checks++;
            if (e.edge_no != edge_cnt || ap !== e.p || ad !== e.d || al != e.lvl || ar !== e.rgb) begin
                failures++;
                $display("FAIL %s dut=%0d edge=%0d/%0d: got pause=%0b dimmed=%0b lvl=%0d rgb=%h, want pause=%0b dimmed=%0b lvl=%0d rgb=%h",
                         e.nm, e.dut, edge_cnt, e.edge_no, ap, ad, al, ar, e.p, e.d, e.lvl, e.rgb);
            end
        end
    end

    task automatic push(input int dut, input int j, input bit p, input bit d, input int lvl,
                        input logic [11:0] rgb, input string nm);
        exp_t x;
        x.edge_no = base + j; x.dut = dut; x.p = p; x.d = d; x.lvl = lvl; x.rgb = rgb; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic until_edge(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        a_if.pause_btn = 1'b0; a_if.pause_req = 1'b0; a_if.wake = 1'b0; a_if.rgb_in = 12'hFFF;
        b_if.pause_btn = 1'b0; b_if.pause_req = 1'b0; b_if.wake = 1'b0; b_if.rgb_in = 12'hA5C;

        @(negedge clk);
        base = edge_cnt + 1;
        push(0, 0, 0, 0, 0, 12'h000, "reset_state_a");
        push(1, 0, 0, 0, 0, 12'h000, "reset_state_b");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Timeout, fade, then unpause + wake on the same edge while dimmed
        base = edge_cnt + 1;
        a_if.pause_btn = 1'b1;
        push(0, 0,  1, 0, 0, 12'hFFF, "t1_pause");
        push(0, 11, 1, 0, 0, 12'hFFF, "t1_fading_entry");
        push(0, 14, 1, 0, 0, 12'hFFF, "t1_before_step");
        push(0, 15, 1, 0, 1, 12'hFFF, "t1_level1");
        push(0, 16, 1, 0, 1, 12'h777, "t1_rgb_777");
        push(0, 18, 1, 0, 1, 12'h777, "t1_hold_level1");
        push(0, 19, 1, 1, 2, 12'h777, "t1_dimmed");
        push(0, 20, 1, 1, 2, 12'h333, "t1_rgb_333");
        push(0, 25, 1, 1, 2, 12'h333, "t1_dimmed_hold");
        push(0, 26, 0, 0, 0, 12'h333, "t1_unpause_beats_wake");
        push(0, 27, 0, 0, 0, 12'hFFF, "t1_rgb_restored");
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        until_edge(base + 25);
        a_if.pause_btn = 1'b1; a_if.wake = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0; a_if.wake = 1'b0;
        until_edge(base + 28);

        // Wake mid-fade restores brightness and restarts the timeout
        base = edge_cnt + 1;
        a_if.pause_btn = 1'b1;
        push(0, 0,  1, 0, 0, 12'hFFF, "t2_pause");
        push(0, 15, 1, 0, 1, 12'hFFF, "t2_level1");
        push(0, 16, 1, 0, 1, 12'h777, "t2_rgb_777");
        push(0, 17, 1, 0, 0, 12'h777, "t2_wake_level0");
        push(0, 18, 1, 0, 0, 12'hFFF, "t2_wake_rgb");
        push(0, 31, 1, 0, 0, 12'hFFF, "t2_refade_not_yet");
        push(0, 32, 1, 0, 1, 12'hFFF, "t2_refade_level1");
        push(0, 33, 1, 0, 1, 12'h777, "t2_refade_rgb");
        push(0, 34, 0, 0, 0, 12'h777, "t2_unpause_fading");
        push(0, 35, 0, 0, 0, 12'hFFF, "t2_unpause_rgb");
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        until_edge(base + 16);
        a_if.wake = 1'b1;
        @(negedge clk);
        a_if.wake = 1'b0;
        until_edge(base + 33);
        a_if.pause_btn = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        until_edge(base + 36);

        // External request, timer restart, and request drop while toggle is set
        base = edge_cnt + 1;
        a_if.pause_req = 1'b1;
        push(0, 0,  1, 0, 0, 12'hFFF, "t3_req_pause");
        push(0, 6,  0, 0, 0, 12'hFFF, "t3_req_drop");
        push(0, 8,  1, 0, 0, 12'hFFF, "t3_req_again");
        push(0, 22, 1, 0, 0, 12'hFFF, "t3_timer_restarted");
        push(0, 23, 1, 0, 1, 12'hFFF, "t3_level1");
        push(0, 24, 1, 0, 1, 12'h777, "t3_toggle_no_effect");
        push(0, 26, 1, 0, 1, 12'h777, "t3_req_drop_no_effect");
        push(0, 27, 1, 1, 2, 12'h777, "t3_dimmed");
        push(0, 28, 1, 1, 2, 12'h333, "t3_rgb_333");
        push(0, 30, 0, 0, 0, 12'h333, "t3_unpause");
        push(0, 31, 0, 0, 0, 12'hFFF, "t3_unpause_rgb");
        until_edge(base + 5);
        a_if.pause_req = 1'b0;
        until_edge(base + 7);
        a_if.pause_req = 1'b1;
        until_edge(base + 23);
        a_if.pause_btn = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0; a_if.pause_req = 1'b0;
        until_edge(base + 29);
        a_if.pause_btn = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        until_edge(base + 32);

        // Async reset mid-fade with the button held through release
        base = edge_cnt + 1;
        a_if.pause_btn = 1'b1;
        push(0, 0,  1, 0, 0, 12'hFFF, "t4_pause");
        push(0, 16, 1, 0, 1, 12'h777, "t4_fading");
        push(0, 18, 0, 0, 0, 12'h000, "t4_async_reset");
        push(0, 19, 0, 0, 0, 12'h000, "t4_reset_held");
        push(0, 21, 0, 0, 0, 12'hFFF, "t4_held_btn_no_toggle");
        push(0, 25, 0, 0, 0, 12'hFFF, "t4_still_running");
        push(0, 26, 1, 0, 0, 12'hFFF, "t4_new_press");
        push(0, 28, 0, 0, 0, 12'hFFF, "t4_unpause");
        until_edge(base + 17);
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        until_edge(base + 24);
        a_if.pause_btn = 1'b0;
        @(negedge clk);
        a_if.pause_btn = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        @(negedge clk);
        a_if.pause_btn = 1'b1;
        @(negedge clk);
        a_if.pause_btn = 1'b0;
        until_edge(base + 29);

        // Full-shift bound on instance B with a mixed-channel pixel
        base = edge_cnt + 1;
        b_if.pause_btn = 1'b1;
        push(1, 0,    1, 0, 0, 12'hA5C, "t5_pause");
        push(1, 4,    1, 0, 0, 12'hA5C, "t5_fading");
        push(1, 5,    1, 0, 1, 12'hA5C, "t5_level1");
        push(1, 6,    1, 0, 1, 12'h526, "t5_rgb_shift1");
        push(1, 8,    1, 0, 2, 12'h213, "t5_rgb_shift2");
        push(1, 10,   1, 0, 3, 12'h101, "t5_rgb_shift3");
        push(1, 11,   1, 1, 4, 12'h101, "t5_dimmed");
        push(1, 12,   1, 1, 4, 12'h000, "t5_rgb_zero");
        push(1, 1012, 1, 1, 4, 12'h000, "t5_hold_1000");
        push(1, 1013, 0, 0, 0, 12'h000, "t5_unpause");
        push(1, 1014, 0, 0, 0, 12'hA5C, "t5_unpause_rgb");
        @(negedge clk);
        b_if.pause_btn = 1'b0;
        until_edge(base + 1012);
        b_if.pause_btn = 1'b1;
        @(negedge clk);
        b_if.pause_btn = 1'b0;
        until_edge(base + 1015);

        repeat (20) begin
            if (sb.size() > 0) @(negedge clk);
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
